// File: rtl/board_io_pkg.sv
// Shared types and the 7-segment hex decode table for the board I/O front-end.
package board_io_pkg;

   typedef logic [6:0] seg_t;

   // Segment patterns are {g,f,e,d,c,b,a}, active-high; drivers invert for the pins.
   localparam seg_t SEG_OFF = 7'h7F;

   localparam seg_t SEG_HEX [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   function automatic seg_t hex7(input logic [3:0] nibble);
      return SEG_HEX[nibble];
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Per-button debouncer with press pulse; auto-repeat is built only when
// BOARD_IO_AUTOREPEAT_EN is defined.
module btn_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned REPEAT_DELAY    = 50000000,
   parameter int unsigned REPEAT_RATE     = 10000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sync_in,
   output logic level,
   output logic press
);

   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);

   logic [CNT_W-1:0] cnt;
   logic             level_q;
   logic             rise_c;
   logic             repeat_c;

   assign rise_c = level & ~level_q;

   // Level flips only after the synchronised input has differed for DEBOUNCE_CYCLES cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt     <= '0;
         level   <= 1'b0;
         level_q <= 1'b0;
         press   <= 1'b0;
      end else begin
         level_q <= level;
         press   <= rise_c | repeat_c;
         if (sync_in == level) begin
            cnt <= '0;
         end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            cnt   <= '0;
            level <= ~level;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

`ifdef BOARD_IO_AUTOREPEAT_EN
   localparam int unsigned HOLD_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int unsigned HOLD_W   = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;

   logic [HOLD_W-1:0] hold;
   logic              repeating;

   // First repeat after REPEAT_DELAY held cycles, later ones every REPEAT_RATE.
   always_comb begin
      repeat_c = 1'b0;
      if (level) begin
         if (repeating) repeat_c = (hold == HOLD_W'(REPEAT_RATE - 1));
         else           repeat_c = (hold == HOLD_W'(REPEAT_DELAY - 1));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold      <= '0;
         repeating <= 1'b0;
      end else if (!level) begin
         hold      <= '0;
         repeating <= 1'b0;
      end else if (repeat_c) begin
         hold      <= '0;
         repeating <= 1'b1;
      end else begin
         hold <= hold + 1'b1;
      end
   end
`else
   // No hold counter in this build; the repeat timing is only referenced, never used.
   localparam bit REPEAT_CFG_OK = (REPEAT_DELAY > 1) && (REPEAT_RATE > 0);
   assign repeat_c = REPEAT_CFG_OK & 1'b0;
`endif

endmodule

// File: rtl/board_io_frontend.sv
// Board I/O front-end: switch/button sync, debounce, LED page select, 7-seg scan.
// Optional auto-repeat of button presses via BOARD_IO_AUTOREPEAT_EN.
module board_io_frontend
   import board_io_pkg::*;
#(
   parameter int unsigned NUM_SW          = 16,
   parameter int unsigned NUM_BTN         = 5,
   parameter int unsigned NUM_DIGITS      = 4,
   parameter int unsigned NUM_PAGES       = 4,
   parameter int unsigned LED_W           = 16,
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned SCAN_CYCLES     = 100000,
   parameter int unsigned PAGE_BTN        = 0,
   parameter int unsigned REPEAT_DELAY    = 50000000,
   parameter int unsigned REPEAT_RATE     = 10000000
) (
   input  logic                                              clk,
   input  logic                                              rst_n,
   input  logic [NUM_SW-1:0]                                 sw_raw,
   input  logic [NUM_BTN-1:0]                                btn_raw,
   output logic [NUM_SW-1:0]                                 sw_sync,
   output logic [NUM_BTN-1:0]                                btn_level,
   output logic [NUM_BTN-1:0]                                btn_press,
   input  logic [NUM_PAGES*LED_W-1:0]                        page_data,
   output logic [((NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1)-1:0] page_sel,
   output logic [LED_W-1:0]                                  led,
   input  logic [4*NUM_DIGITS-1:0]                           disp_value,
   input  logic [NUM_DIGITS-1:0]                             disp_dp,
   input  logic [NUM_DIGITS-1:0]                             disp_blank,
   output logic [6:0]                                        seg,
   output logic [NUM_DIGITS-1:0]                             an,
   output logic                                              dp
);

   localparam int unsigned PAGE_W = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1;
   localparam int unsigned DIG_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int unsigned SCAN_W = $clog2(SCAN_CYCLES);

   logic [NUM_SW-1:0]  sw_meta;
   logic [NUM_BTN-1:0] btn_meta;
   logic [NUM_BTN-1:0] btn_sync;
   logic [SCAN_W-1:0]  presc;
   logic [DIG_W-1:0]   digit;

   // Two-flop synchronisers on every raw pin.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sw_meta  <= '0;
         sw_sync  <= '0;
         btn_meta <= '0;
         btn_sync <= '0;
      end else begin
         sw_meta  <= sw_raw;
         sw_sync  <= sw_meta;
         btn_meta <= btn_raw;
         btn_sync <= btn_meta;
      end
   end

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
      btn_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .REPEAT_DELAY    (REPEAT_DELAY),
         .REPEAT_RATE     (REPEAT_RATE)
      ) u_btn (
         .clk     (clk),
         .rst_n   (rst_n),
         .sync_in (btn_sync[i]),
         .level   (btn_level[i]),
         .press   (btn_press[i])
      );
   end

   // LED page cycling; the LEDs always mirror the selected page one cycle later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         page_sel <= '0;
         led      <= '0;
      end else begin
         if (btn_press[PAGE_BTN]) begin
            page_sel <= (page_sel == PAGE_W'(NUM_PAGES - 1)) ? '0 : page_sel + 1'b1;
         end
         led <= page_data[page_sel*LED_W +: LED_W];
      end
   end

   // Digit scan: prescaler advances the active digit, outputs register the active digit's drive.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc <= '0;
         digit <= '0;
         seg   <= SEG_OFF;
         an    <= '1;
         dp    <= 1'b1;
      end else begin
         if (presc == SCAN_W'(SCAN_CYCLES - 1)) begin
            presc <= '0;
            digit <= (digit == DIG_W'(NUM_DIGITS - 1)) ? '0 : digit + 1'b1;
         end else begin
            presc <= presc + 1'b1;
         end
         seg <= ~hex7(disp_value[digit*4 +: 4]);
         dp  <= ~disp_dp[digit];
         an  <= disp_blank[digit] ? '1 : ~(NUM_DIGITS'(1) << digit);
      end
   end

endmodule

// File: tb/tb_board_io_frontend.sv
// Scoreboard bench for board_io_frontend: directed stimulus queues expectations,
// a negedge monitor pops and compares them.
module tb_board_io_frontend;

   localparam int unsigned NUM_SW     = 16;
   localparam int unsigned NUM_BTN    = 5;
   localparam int unsigned NUM_DIGITS = 4;
   localparam int unsigned NUM_PAGES  = 4;
   localparam int unsigned LED_W      = 16;

   localparam int K_LEVEL = 0, K_LED = 1, K_PAGE = 2, K_AN = 3, K_SEG = 4, K_DP = 5, K_SW = 6;

   // ~SEG_HEX of F, A, 2, 1 (digits 0..3 of 16'h12AF)
   localparam logic [6:0]  SEG_EXP [4] = '{7'h0E, 7'h08, 7'h24, 7'h79};
   localparam logic [15:0] WORDS   [4] = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD};

   typedef struct { int cyc; int kind; logic [31:0] val; } samp_t;
   typedef struct { int cyc; logic [NUM_BTN-1:0] mask; } press_t;

   samp_t  samp_q[$];
   press_t press_q[$];
   int     checks = 0;
   int     errors = 0;
   int     cyc = 0;
   int     scan_base = 0;
   logic   end_req = 1'b0;

   logic                         clk = 1'b0;
   logic                         rst_n;
   logic [NUM_SW-1:0]            sw_raw;
   logic [NUM_BTN-1:0]           btn_raw;
   logic [NUM_SW-1:0]            sw_sync;
   logic [NUM_BTN-1:0]           btn_level;
   logic [NUM_BTN-1:0]           btn_press;
   logic [NUM_PAGES*LED_W-1:0]   page_data;
   logic [1:0]                   page_sel;
   logic [LED_W-1:0]             led;
   logic [4*NUM_DIGITS-1:0]      disp_value;
   logic [NUM_DIGITS-1:0]        disp_dp;
   logic [NUM_DIGITS-1:0]        disp_blank;
   logic [6:0]                   seg;
   logic [NUM_DIGITS-1:0]        an;
   logic                         dp;

   board_io_frontend #(
      .NUM_SW(NUM_SW), .NUM_BTN(NUM_BTN), .NUM_DIGITS(NUM_DIGITS), .NUM_PAGES(NUM_PAGES),
      .LED_W(LED_W), .DEBOUNCE_CYCLES(4), .SCAN_CYCLES(3), .PAGE_BTN(0),
      .REPEAT_DELAY(8), .REPEAT_RATE(5)
   ) dut (
      .clk(clk), .rst_n(rst_n), .sw_raw(sw_raw), .btn_raw(btn_raw),
      .sw_sync(sw_sync), .btn_level(btn_level), .btn_press(btn_press),
      .page_data(page_data), .page_sel(page_sel), .led(led),
      .disp_value(disp_value), .disp_dp(disp_dp), .disp_blank(disp_blank),
      .seg(seg), .an(an), .dp(dp)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic string kname(input int k);
      case (k)
         K_LEVEL: return "btn_level";
         K_LED:   return "led";
         K_PAGE:  return "page_sel";
         K_AN:    return "an";
         K_SEG:   return "seg";
         K_DP:    return "dp";
         default: return "sw_sync";
      endcase
   endfunction

   function automatic logic [31:0] actual(input int k);
      case (k)
         K_LEVEL: return 32'(btn_level);
         K_LED:   return 32'(led);
         K_PAGE:  return 32'(page_sel);
         K_AN:    return 32'(an);
         K_SEG:   return 32'(seg);
         K_DP:    return 32'(dp);
         default: return 32'(sw_sync);
      endcase
   endfunction

   // Digit whose drive is visible at negedge of cycle c, counted from reset release.
   function automatic int digit_at(input int c);
      return ((c - scan_base - 1) / 3) % 4;
   endfunction

   function automatic logic [3:0] an_of(input int d);
      logic [3:0] oh;
      oh = 4'b0001 << d;
      return ~oh;
   endfunction

   task automatic expect_at(input int c, input int k, input logic [31:0] v);
      samp_t s;
      int    i;
      s.cyc = c; s.kind = k; s.val = v;
      i = samp_q.size();
      while (i > 0 && samp_q[i-1].cyc > c) i--;
      samp_q.insert(i, s);
   endtask

   task automatic expect_press(input int c, input logic [NUM_BTN-1:0] m);
      press_t p;
      p.cyc = c; p.mask = m;
      press_q.push_back(p);
   endtask

   task automatic expect_reset_state(input int c);
      expect_at(c, K_SEG, 32'h7F);
      expect_at(c, K_AN, 32'hF);
      expect_at(c, K_DP, 32'h1);
      expect_at(c, K_LED, 32'h0);
      expect_at(c, K_PAGE, 32'h0);
      expect_at(c, K_LEVEL, 32'h0);
      expect_at(c, K_SW, 32'h0);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Monitor: pops press expectations on every pulse and timed samples on their cycle.
   always @(negedge clk) begin
      samp_t  s;
      press_t p;
      if (btn_press !== '0) begin
         checks++;
         if (press_q.size() == 0) begin
            errors++;
            $display("FAIL btn_press cyc=%0d got=%b required=none", cyc, btn_press);
         end else begin
            p = press_q.pop_front();
            if (p.cyc != cyc || p.mask !== btn_press) begin
               errors++;
               $display("FAIL btn_press cyc=%0d got=%b required=%b at cyc %0d", cyc, btn_press, p.mask, p.cyc);
            end
         end
      end
      while (samp_q.size() > 0 && samp_q[0].cyc <= cyc) begin
         s = samp_q.pop_front();
         checks++;
         if (s.cyc != cyc || actual(s.kind) !== s.val) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h required=%h (due cyc %0d)", kname(s.kind), cyc, actual(s.kind), s.val, s.cyc);
         end
      end
      if (end_req) begin
         while (press_q.size() > 0) begin
            p = press_q.pop_front();
            checks++;
            errors++;
            $display("FAIL btn_press_missing got=none required=%b at cyc %0d", p.mask, p.cyc);
         end
         while (samp_q.size() > 0) begin
            s = samp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL %s_unchecked got=none required=%h at cyc %0d", kname(s.kind), s.val, s.cyc);
         end
         $display("Simulation finished: %0d checks, %0d errors", checks, errors);
         $finish;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog cyc=%0d got=no end required=end of stimulus", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int c;
      int r;
      int a;
      int d;
      rst_n      = 1'b1;
      sw_raw     = 16'hA5C3;
      btn_raw    = '0;
      page_data  = {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA};
      disp_value = 16'h12AF;
      disp_dp    = 4'b0100;
      disp_blank = 4'b0000;
      #2 rst_n = 1'b0;
      tick(3);
      expect_reset_state(cyc);

      // Release reset: switch sync latency and a full scan of all four digits.
      rst_n = 1'b1;
      c = cyc;
      scan_base = c;
      expect_at(c + 1, K_SW, 32'h0);
      expect_at(c + 2, K_SW, 32'hA5C3);
      expect_at(c + 1, K_LED, 32'hAAAA);
      for (int k = 1; k <= 12; k++) begin
         d = (k - 1) / 3;
         expect_at(c + k, K_AN, 32'(an_of(d)));
         expect_at(c + k, K_SEG, 32'(SEG_EXP[d]));
         expect_at(c + k, K_DP, (d == 2) ? 32'h0 : 32'h1);
      end
      tick(12);

      // Blank digit 1 only.
      disp_blank = 4'b0010;
      c = cyc;
      for (int k = 1; k <= 12; k++) begin
         d = digit_at(c + k);
         expect_at(c + k, K_AN, (d == 1) ? 32'hF : 32'(an_of(d)));
      end
      tick(12);
      disp_blank = 4'b0000;

      // 3-cycle glitch on button 1 must be rejected.
      c = cyc;
      btn_raw[1] = 1'b1;
      for (int k = 1; k <= 10; k++) expect_at(c + k, K_LEVEL, 32'h0);
      tick(3);
      btn_raw[1] = 1'b0;
      tick(10);

      // Clean 10-cycle press of button 1.
      c = cyc;
      btn_raw[1] = 1'b1;
      expect_at(c + 5, K_LEVEL, 32'h0);
      expect_at(c + 6, K_LEVEL, 32'h2);
      expect_press(c + 7, 5'b00010);
`ifdef BOARD_IO_AUTOREPEAT_EN
      expect_press(c + 14, 5'b00010);
`endif
      tick(10);
      btn_raw[1] = 1'b0;
      r = cyc;
      expect_at(r + 5, K_LEVEL, 32'h2);
      expect_at(r + 6, K_LEVEL, 32'h0);
      tick(12);

      // Six presses of the page button: 1,2,3,0 (wrap),1,2.
      for (int p = 0; p < 6; p++) begin
         c = cyc;
         btn_raw[0] = 1'b1;
         expect_press(c + 7, 5'b00001);
         expect_at(c + 7, K_PAGE, 32'(p % 4));
         expect_at(c + 8, K_PAGE, 32'((p + 1) % 4));
         expect_at(c + 8, K_LED, 32'(WORDS[p % 4]));
         expect_at(c + 9, K_LED, 32'(WORDS[(p + 1) % 4]));
         tick(5);
         btn_raw[0] = 1'b0;
         tick(12);
      end

      // Reset while button 2 debounces, page 2 selected and digit 3 displayed.
      while (!(digit_at(cyc + 2) == 3 && digit_at(cyc + 3) == 3)) tick(1);
      c = cyc;
      expect_at(c, K_PAGE, 32'h2);
      expect_at(c + 2, K_AN, 32'h7);
      btn_raw[2] = 1'b1;
      tick(3);
      rst_n = 1'b0;
      expect_reset_state(cyc);
      tick(2);
      rst_n = 1'b1;
      r = cyc;
      scan_base = r;
      expect_at(r + 1, K_AN, 32'hE);
      expect_at(r + 1, K_PAGE, 32'h0);
      expect_at(r + 1, K_LED, 32'hAAAA);
      expect_at(r + 5, K_LEVEL, 32'h0);
      expect_at(r + 6, K_LEVEL, 32'h4);
      expect_press(r + 7, 5'b00100);
      tick(6);
      btn_raw[2] = 1'b0;
      tick(15);

`ifdef BOARD_IO_AUTOREPEAT_EN
      // Hold page button 30 cycles past acceptance: press plus five repeats.
      c = cyc;
      a = c + 6;
      btn_raw[0] = 1'b1;
      expect_press(a + 1, 5'b00001);
      expect_press(a + 8, 5'b00001);
      expect_press(a + 13, 5'b00001);
      expect_press(a + 18, 5'b00001);
      expect_press(a + 23, 5'b00001);
      expect_press(a + 28, 5'b00001);
      expect_at(a + 2, K_PAGE, 32'h1);
      expect_at(a + 9, K_PAGE, 32'h2);
      expect_at(a + 30, K_PAGE, 32'h2);
      expect_at(a + 31, K_LED, 32'hCCCC);
      tick(30);
      btn_raw[0] = 1'b0;
      tick(15);
`else
      a = 0;
`endif

      tick(5);
      end_req = 1'b1;
      @(negedge clk);
      #1;
   end

endmodule

// File: doc/board_io_frontend.md
Name: board_io_frontend

Overview:
Parametrised Basys3-class board I/O front-end that sits between the top-level pins and the TPU core.
- Synchronises switches; synchronises and debounces buttons, and generates press pulses.
- Drives a time-multiplexed N-digit 7-segment display from a hex value.
- Selects one of several LED status pages, cycled by a dedicated button.
- Replaces ad-hoc per-board pin glue with one reusable, width-generic block.

Parameters:
NUM_SW, 16, switch input count
NUM_BTN, 5, button input count
NUM_DIGITS, 4, 7-segment digit count (>=1)
NUM_PAGES, 4, LED status pages (>=1)
LED_W, 16, LED count / page width
DEBOUNCE_CYCLES, 1000000, consecutive stable cycles to accept a button change (>=2)
SCAN_CYCLES, 100000, clock cycles per displayed digit (>=2)
PAGE_BTN, 0, button index that advances the LED page (< NUM_BTN)
REPEAT_DELAY, 50000000, hold cycles before the first auto-repeat (optional feature only)
REPEAT_RATE, 10000000, cycles between auto-repeats (optional feature only)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
sw_raw  in  NUM_SW  raw switch pins
btn_raw  in  NUM_BTN  raw button pins, active-high
sw_sync  out  NUM_SW  synchronised switch levels
btn_level  out  NUM_BTN  debounced button levels
btn_press  out  NUM_BTN  one-cycle pulse per accepted press
page_data  in  NUM_PAGES*LED_W  status words; page p occupies bits [p*LED_W +: LED_W]
page_sel  out  max(1,$clog2(NUM_PAGES))  current LED page
led  out  LED_W  registered copy of the selected page
disp_value  in  4*NUM_DIGITS  hex nibbles; digit d uses bits [4d +: 4]
disp_dp  in  NUM_DIGITS  decimal point per digit, active-high
disp_blank  in  NUM_DIGITS  blank per digit, active-high
seg  out  7  segments {g..a}, active-low
an  out  NUM_DIGITS  anodes, active-low, at most one low
dp  out  1  decimal point, active-low

Behaviour:
- One clock domain: clk. Reset is asynchronous on assert, active-low (rst_n); all flops clear on assert.
- Reset values:
  - sync flops, sw_sync, btn_level, btn_press, page_sel, led: 0.
  - seg = 7'h7F, an all 1, dp = 1.
  - Digit index, scan prescaler, debounce counters: 0.
- Synchroniser: two flops on every sw_raw and btn_raw bit. sw_sync lags sw_raw by 2 cycles. No debounce on switches.
- Debounce (per button, independent):
  - Counter increments while sync_in != btn_level, and clears whenever they agree.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, btn_level toggles on the next edge and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES never changes btn_level.
- Press pulse:
  - btn_press[i] = 1 for exactly the cycle after btn_level[i] goes 0->1. No pulse on release.
  - Simultaneous presses on different buttons pulse independently in the same cycle.
- Page select:
  - btn_press[PAGE_BTN] advances page_sel by 1; NUM_PAGES-1 wraps to 0.
  - With NUM_PAGES=1, page_sel stays 0.
  - led <= page slice of page_sel every cycle (1-cycle latency from page_data or page_sel).
- Scan:
  - Prescaler counts 0..SCAN_CYCLES-1. On terminal count it clears and the digit index advances, wrapping NUM_DIGITS-1 -> 0.
  - Every cycle, registered outputs are:
    - seg = ~hex7(nibble[idx]).
    - dp = ~disp_dp[idx].
    - an = all ones except bit idx, which is low; an is all ones if disp_blank[idx].
  - Input changes appear one cycle later.
- Hex decode is the standard 0-F table, with lowercase b and d.
- Reset mid-debounce or mid-scan: everything returns to reset values. No press pulse is emitted for a button still held at release of rst_n until a fresh 0->1 is accepted after debounce.

Optional Feature:
Macro BOARD_IO_AUTOREPEAT_EN.
- Defined:
  - While btn_level[i] stays 1, a hold counter runs.
  - An extra btn_press[i] pulse fires after REPEAT_DELAY cycles, then every REPEAT_RATE cycles.
  - Release or reset clears the hold counter.
  - Page select therefore auto-advances while PAGE_BTN is held.
- Undefined: no hold counters are built, and exactly one pulse is produced per press.

Decomposition:
- Package board_io_pkg:
  - seg_t (logic [6:0]).
  - SEG_HEX[16] constant table (active-high) and function hex7(nibble) returning seg_t.
  - SEG_OFF constant.
- Sub-module btn_debounce, one per button, instanced in a generate loop. Each instance holds the counter, the level, the press pulse and the optional auto-repeat logic.
- The synchroniser, page mux and scan driver stay in the top.

Test Plan:
Bench parameters: DEBOUNCE_CYCLES=4, SCAN_CYCLES=3, NUM_DIGITS=4, NUM_PAGES=4.
- Debounce reject and accept:
  - btn_raw[1] high for 3 cycles then low -> btn_level[1] stays 0 and no btn_press.
  - btn_raw[1] held high for 10 cycles -> btn_level[1] rises 2+4 cycles after the edge, and btn_press[1] pulses exactly once the cycle after.
- Page wrap: page_data = {16'hDDDD,16'hCCCC,16'hBBBB,16'hAAAA}, five clean presses of btn 0 -> led sequence AAAA, BBBB, CCCC, DDDD, AAAA, with page_sel 0,1,2,3,0.
- Scan: disp_value=16'h12AF, disp_dp=4'b0100, disp_blank=0 -> an cycles 1110, 1101, 1011, 0111, changing every 3 cycles.
  - seg = ~SEG_HEX of F, A, 2, 1 in that order.
  - dp low only while an=1011.
- Blank: disp_blank=4'b0010 -> an stays 1111 during digit 1's 3-cycle slot; the other digits are unchanged.
- Reset mid-operation:
  - Drop rst_n while btn 2 is debouncing and on page 2 with digit 3 active -> all outputs take reset values immediately.
  - After release with btn_raw[2] still high -> a single btn_press[2] after 6 cycles.
- Auto-repeat (BOARD_IO_AUTOREPEAT_EN, REPEAT_DELAY=8, REPEAT_RATE=5): hold btn 0 for 30 cycles after acceptance -> pulses at acceptance+1, +8, +13, +18, +23, +28. page_sel advances for each pulse.
